// File: rtl/nested_struct_dispatch_if.sv
// rtl/nested_struct_dispatch_if.sv - record stream and debug bus for nested_struct_dispatch
//   master: drives in_data/in_strobe/out_ready, observes head fields and debug state
//   slave : the dispatcher side of the same signals
interface nested_struct_dispatch_if #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [61:0]       in_data;
  logic              in_strobe;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_addr;
  logic [31:0]       out_data;
  logic [15:0]       out_id;
  logic [3:0]        out_cmd;
  logic              out_flag;
  logic [LW-1:0]     level;
  logic [DROP_W-1:0] drop_count;
  logic              seq_err;

  modport master (
    output in_data, in_strobe, out_ready,
    input  out_valid, out_addr, out_data, out_id, out_cmd, out_flag,
    input  level, drop_count, seq_err
  );

  modport slave (
    input  in_data, in_strobe, out_ready,
    output out_valid, out_addr, out_data, out_id, out_cmd, out_flag,
    output level, drop_count, seq_err
  );
endinterface

// File: rtl/nested_struct_dispatch.sv
// rtl/nested_struct_dispatch.sv - filters, buffers and unpacks flattened nested-struct records
//   clk, rst     : single clock, synchronous active-high reset
//   bus (slave)  : in_data/in_strobe record input, out_* head fields with out_valid/out_ready,
//                  level occupancy, saturating drop_count, sticky seq_err
module nested_struct_dispatch #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input logic                   clk,
  input logic                   rst,
  nested_struct_dispatch_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // base.valid is always 1 for stored records, so only [61:1] is kept.
  logic [61:1]       mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DROP_W-1:0] drop_count_q, drop_count_d;
  logic              seq_err_q, seq_err_d;
  logic              seen_q, seen_d;
  logic [15:0]       exp_id_q, exp_id_d;

  logic        candidate, full, not_empty, pop, push, drop;
  logic [15:0] in_id;
  logic [61:1] head;

  assign in_id     = bus.in_data[56:41];
  assign candidate = bus.in_strobe & bus.in_data[0];
  assign not_empty = (level_q != '0);
  assign full      = (level_q == LW'(DEPTH));
  assign pop       = not_empty & bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push      = candidate & (~full | pop);
  assign drop      = candidate & full & ~pop;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    drop_count_d = drop_count_q;
    seq_err_d    = seq_err_q;
    seen_d       = seen_q;
    exp_id_d     = exp_id_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (drop && (drop_count_q != {DROP_W{1'b1}})) drop_count_d = drop_count_q + DROP_W'(1);

    // The first accepted record only seeds the expectation.
    if (push) begin
      if (seen_q && (in_id != exp_id_q)) seq_err_d = 1'b1;
      seen_d   = 1'b1;
      exp_id_d = in_id + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      drop_count_q <= '0;
      seq_err_q    <= 1'b0;
      seen_q       <= 1'b0;
      exp_id_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      drop_count_q <= drop_count_d;
      seq_err_q    <= seq_err_d;
      seen_q       <= seen_d;
      exp_id_q     <= exp_id_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= bus.in_data[61:1];
  end

  // Head fields come straight from storage at the registered read pointer; forced to 0 when empty.
  assign head           = not_empty ? mem_q[rd_ptr_q] : '0;
  assign bus.out_valid  = not_empty;
  assign bus.out_flag   = head[61];
  assign bus.out_cmd    = head[60:57];
  assign bus.out_id     = head[56:41];
  assign bus.out_addr   = head[40:33];
  assign bus.out_data   = head[32:1];
  assign bus.level      = level_q;
  assign bus.drop_count = drop_count_q;
  assign bus.seq_err    = seq_err_q;
endmodule

// File: tb/tb_nested_struct_dispatch.sv
// tb/tb_nested_struct_dispatch.sv - self-checking bench for nested_struct_dispatch
module tb_nested_struct_dispatch;
  localparam int DEPTH  = 4;
  localparam int DROP_W = 8;
  localparam int DMAX   = (1 << DROP_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nested_struct_dispatch_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();
  nested_struct_dispatch #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of accepted records plus counters.
  logic [61:0] mq [$];
  int          m_drop;
  bit          m_seq_err;
  bit          m_seen;
  int          m_exp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [61:0] rec(input logic flag, input logic [3:0] cmd, input logic [15:0] id,
                                      input logic [7:0] addr, input logic [31:0] data, input logic v);
    return {flag, cmd, id, addr, data, v};
  endfunction

  task automatic model_step(input logic r, input logic strobe, input logic [61:0] d, input logic rdy);
    bit cand, full, pop;
    int id;
    if (r) begin
      mq.delete();
      m_drop = 0; m_seq_err = 0; m_seen = 0; m_exp = 0;
      return;
    end
    cand = strobe && d[0];
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && rdy;
    if (pop) void'(mq.pop_front());
    if (cand) begin
      if (!full || pop) begin
        mq.push_back(d);
        id = int'(d[56:41]);
        if (m_seen && id != m_exp) m_seq_err = 1;
        m_seen = 1;
        m_exp  = (id + 1) % 65536;
      end else if (m_drop < DMAX) begin
        m_drop++;
      end
    end
  endtask

  task automatic check_outputs();
    logic [61:0] h;
    h = (mq.size() != 0) ? mq[0] : 62'd0;
    chk("out_valid",  bus.out_valid,  mq.size() != 0);
    chk("out_flag",   bus.out_flag,   h[61]);
    chk("out_cmd",    bus.out_cmd,    h[60:57]);
    chk("out_id",     bus.out_id,     h[56:41]);
    chk("out_addr",   bus.out_addr,   h[40:33]);
    chk("out_data",   bus.out_data,   h[32:1]);
    chk("level",      bus.level,      mq.size());
    chk("drop_count", bus.drop_count, m_drop);
    chk("seq_err",    bus.seq_err,    m_seq_err);
  endtask

  task automatic cycle(input logic r, input logic strobe, input logic [61:0] d, input logic rdy);
    rst           = r;
    bus.in_strobe = strobe;
    bus.in_data   = d;
    bus.out_ready = rdy;
    @(posedge clk);
    model_step(r, strobe, d, rdy);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 62'd0, 1'b0);
    cycle(1'b1, 1'b0, 62'd0, 1'b0);
  endtask

  task automatic send(input logic [15:0] id, input logic [7:0] addr, input logic rdy);
    cycle(1'b0, 1'b1, rec(1'b1, 4'h3, id, addr, $urandom, 1'b1), rdy);
  endtask

  initial begin
    logic [15:0] rid;
    bus.in_strobe = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;

    // Reset state
    do_reset();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_level", bus.level, 0);

    // Three in-order records straight through
    send(16'd5, 8'h10, 1'b1);
    chk("t1_id5", bus.out_id, 5);
    chk("t1_addr10", bus.out_addr, 8'h10);
    send(16'd6, 8'h11, 1'b1);
    send(16'd7, 8'h12, 1'b1);
    chk("t1_id7", bus.out_id, 7);
    chk("t1_level", bus.level, 1);
    chk("t1_seq", bus.seq_err, 0);

    // Overfill with sink stalled, then drain
    do_reset();
    for (int i = 0; i < 6; i++) send(16'(i), 8'(i), 1'b0);
    chk("t2_level", bus.level, 4);
    chk("t2_drop", bus.drop_count, 2);
    chk("t2_head", bus.out_id, 0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 62'd0, 1'b1);
    chk("t2_empty", bus.level, 0);

    // Full FIFO with simultaneous pop and push
    do_reset();
    for (int i = 0; i < 4; i++) send(16'(10 + i), 8'h20, 1'b0);
    send(16'd14, 8'h21, 1'b1);
    chk("t3_level", bus.level, 4);
    chk("t3_drop", bus.drop_count, 0);
    chk("t3_head", bus.out_id, 11);

    // ID wrap then a gap
    do_reset();
    send(16'hFFFE, 8'h0, 1'b1);
    send(16'hFFFF, 8'h0, 1'b1);
    send(16'h0000, 8'h0, 1'b1);
    chk("t4_wrap", bus.seq_err, 0);
    send(16'h0005, 8'h0, 1'b1);
    chk("t4_gap", bus.seq_err, 1);
    send(16'h0006, 8'h0, 1'b1);
    chk("t4_sticky", bus.seq_err, 1);

    // Invalid strobe is ignored
    do_reset();
    send(16'd1, 8'h1, 1'b0);
    cycle(1'b0, 1'b1, rec(1'b0, 4'h0, 16'd77, 8'h0, 32'hDEADBEEF, 1'b0), 1'b0);
    chk("t5_level", bus.level, 1);
    chk("t5_seq", bus.seq_err, 0);

    // Drop counter saturation
    do_reset();
    for (int i = 0; i < 4 + 300; i++) send(16'(i), 8'h0, 1'b0);
    chk("t6_sat", bus.drop_count, DMAX);

    // Reset mid-stream with a push and pop attempted in the same cycle
    do_reset();
    for (int i = 0; i < 3; i++) send(16'(i + 40), 8'h0, 1'b0);
    chk("t7_level3", bus.level, 3);
    cycle(1'b1, 1'b1, rec(1'b1, 4'h1, 16'd9, 8'h9, 32'h9, 1'b1), 1'b1);
    chk("t7_level", bus.level, 0);
    chk("t7_valid", bus.out_valid, 0);
    chk("t7_drop", bus.drop_count, 0);
    chk("t7_seq", bus.seq_err, 0);

    // Randomized traffic against the queue model
    do_reset();
    rid = 16'($urandom);
    for (int i = 0; i < 2000; i++) begin
      logic [61:0] d;
      logic        r;
      if ($urandom_range(0, 9) == 0) rid = 16'($urandom);
      d = rec(1'($urandom), 4'($urandom), rid, 8'($urandom), $urandom,
              1'($urandom_range(0, 7) != 0));
      r = ($urandom_range(0, 99) == 0);
      cycle(r, 1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) != 0));
      rid = rid + 16'd1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
